// File: rtl/nonblk_slot_drain.sv
// nonblk_slot_drain: slot register array with per-slot dirty bits, drained one
// updated slot at a time in round-robin order over a valid/ready (index, data) stream.
// Optional lost-update counter (ovf_cnt port) enabled by defining NONBLK_SLOT_OVF_EN.
module nonblk_slot_drain #(
    parameter  int N  = 12,
    parameter  int W  = 1,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   wr_en,
    input  logic [N*W-1:0] wr_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IW-1:0]  out_idx,
    output logic [W-1:0]   out_data
`ifdef NONBLK_SLOT_OVF_EN
    ,
    output logic [7:0]     ovf_cnt
`endif
);

    localparam int IW1 = IW + 1;
    localparam logic [IW:0] NW = IW1'(N);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    slot_reg [N];
    logic [W-1:0]    slot_next [N];
    logic [N-1:0]    dirty_reg, dirty_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]   out_idx_reg, out_idx_next;
    logic [W-1:0]    out_data_reg, out_data_next;
    logic [N-1:0]    sel_hit;
    logic            found, load, take;
    logic [IW-1:0]   sel;
    logic [IW:0]     cand;
    logic [IW:0]     sel_p1;

    // Round-robin search of the registered dirty bits starting at ptr, wrapping N-1 -> 0
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_reg} + IW1'(k);
            if (cand >= NW) cand = cand - NW;
            if (!found && dirty_reg[cand[IW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IW-1:0];
            end
        end
    end

    // FSM next state plus output/pointer updates on a load event
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        out_idx_next  = out_idx_reg;
        out_data_next = out_data_reg;
        load          = (state_reg == IDLE) || out_ready;
        take          = load && found;
        sel_p1        = {1'b0, sel} + IW1'(1);
        if (load) begin
            state_next = found ? HOLD : IDLE;
        end
        if (take) begin
            out_idx_next  = sel;
            out_data_next = slot_reg[sel];
            ptr_next      = (sel_p1 == NW) ? '0 : sel_p1[IW-1:0];
        end
    end

    // Per-slot next values: a write sets dirty and wins over the selection clear
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign sel_hit[gi]    = take && (sel == IW'(gi));
            assign dirty_next[gi] = wr_en[gi] | (dirty_reg[gi] & ~sel_hit[gi]);
            assign slot_next[gi]  = wr_en[gi] ? wr_data[gi*W +: W] : slot_reg[gi];
        end
    endgenerate

    // State, slot storage, dirty bits, pointer and presented pair
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            dirty_reg    <= '0;
            ptr_reg      <= '0;
            out_idx_reg  <= '0;
            out_data_reg <= '0;
            for (int k = 0; k < N; k++) slot_reg[k] <= '0;
        end else begin
            state_reg    <= state_next;
            dirty_reg    <= dirty_next;
            ptr_reg      <= ptr_next;
            out_idx_reg  <= out_idx_next;
            out_data_reg <= out_data_next;
            for (int k = 0; k < N; k++) slot_reg[k] <= slot_next[k];
        end
    end

    assign out_valid = (state_reg == HOLD);
    assign out_idx   = out_idx_reg;
    assign out_data  = out_data_reg;

`ifdef NONBLK_SLOT_OVF_EN
    logic [N-1:0] lost;
    logic [7:0]   ovf_reg, ovf_next;
    int           ovf_sum;

    // A write to a dirty slot that is not being selected overwrites an unreported value
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lost
            assign lost[gi] = wr_en[gi] & dirty_reg[gi] & ~sel_hit[gi];
        end
    endgenerate

    // Saturating accumulate of lost updates this cycle
    always_comb begin
        ovf_sum = int'(ovf_reg);
        for (int k = 0; k < N; k++) ovf_sum = ovf_sum + int'(lost[k]);
        ovf_next = (ovf_sum > 255) ? 8'hFF : 8'(ovf_sum);
    end

    // Lost-update counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) ovf_reg <= '0;
        else        ovf_reg <= ovf_next;
    end

    assign ovf_cnt = ovf_reg;
`endif

endmodule

// File: tb/tb_nonblk_slot_drain.sv
// Directed testbench for nonblk_slot_drain (N=12, W=1): table-driven vectors plus
// hand-written backpressure, lost-update counter and reset-mid-transfer sequences.
module tb_nonblk_slot_drain;

    localparam int N = 12;
    localparam int W = 1;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   wr_en;
    logic [N*W-1:0] wr_data;
    logic           out_valid;
    logic           out_ready;
    logic [3:0]     out_idx;
    logic [W-1:0]   out_data;
`ifdef NONBLK_SLOT_OVF_EN
    logic [7:0]     ovf_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    nonblk_slot_drain #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
`ifdef NONBLK_SLOT_OVF_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] wr_en;
        logic [N-1:0] wr_data;
        logic         rdy;
        logic         ev;
        logic [3:0]   ei;
        logic         ed;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [N-1:0] we, input logic [N-1:0] wd,
                                input logic rd, input logic ev, input logic [3:0] ei,
                                input logic ed);
        vec_t v;
        v.rst_n = r; v.wr_en = we; v.wr_data = wd; v.rdy = rd;
        v.ev = ev; v.ei = ei; v.ed = ed;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp_v);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] we, input logic [N-1:0] wd,
                         input logic rd);
        rst_n = r; wr_en = we; wr_data = wd; out_ready = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [3:0] ei,
                           input logic ed);
        $display("%s: valid=%0d idx=%0d data=%0d", nm, out_valid, out_idx, out_data);
        chk({nm, ".valid"}, 32'(out_valid), 32'(ev));
        chk({nm, ".idx"},   32'(out_idx),   32'(ei));
        chk({nm, ".data"},  32'(out_data),  32'(ed));
    endtask

    logic [N-1:0] pat;
    logic [3:0]   idx;

    initial begin
        drive(1'b0, '0, '0, 1'b0);

        // Reset with all-ones writes, then idle
        add(0, 12'hFFF, 12'hFFF, 1, 0, 0, 0);
        add(0, 12'hFFF, 12'hFFF, 1, 0, 0, 0);
        add(1, 12'h000, 12'h000, 1, 0, 0, 0);
        add(1, 12'h000, 12'h000, 1, 0, 0, 0);
        // Single write to slot 2: visible two cycles later, then back to idle
        add(1, 12'h004, 12'h004, 1, 0, 0, 0);
        add(1, 12'h000, 12'h000, 1, 1, 2, 1);
        add(1, 12'h000, 12'h000, 1, 0, 2, 1);
        // Move ptr to 10 via slot 9, then dirty {1,3,11} while holding
        add(1, 12'h200, 12'h200, 1, 0, 2, 1);
        add(1, 12'h000, 12'h000, 1, 1, 9, 1);
        add(1, 12'h80A, 12'h802, 0, 1, 9, 1);
        add(1, 12'h000, 12'h000, 1, 1, 11, 1);
        add(1, 12'h000, 12'h000, 1, 1, 1, 1);
        add(1, 12'h000, 12'h000, 1, 1, 3, 0);
        add(1, 12'h000, 12'h000, 1, 0, 3, 0);
        // Set-vs-clear race on slot 6: old 1 emitted, then new 0
        add(1, 12'h040, 12'h040, 1, 0, 3, 0);
        add(1, 12'h040, 12'h000, 1, 1, 6, 1);
        add(1, 12'h000, 12'h000, 1, 1, 6, 0);
        add(1, 12'h000, 12'h000, 1, 0, 6, 0);
        // All-ones mask write, drained in round-robin order from ptr 7
        pat = 12'hA5A;
        add(1, 12'hFFF, pat, 1, 0, 6, 0);
        for (int k = 0; k < N; k++) begin
            idx = 4'((7 + k) % N);
            add(1, 12'h000, 12'h000, 1, 1, idx, pat[idx]);
        end
        add(1, 12'h000, 12'h000, 1, 0, 6, pat[6]);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].wr_en, tbl[i].wr_data, tbl[i].rdy);
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ed);
        end
`ifdef NONBLK_SLOT_OVF_EN
        chk("ovf_after_table", 32'(ovf_cnt), 32'd0);
`endif

        // Backpressure: hold idx 5 while slots 5 and 7 are rewritten
        drive(1, 12'h020, 12'h020, 0); step(); chk_out("bp_wr5", 0, 6, pat[6]);
        drive(1, 12'h000, 12'h000, 0); step(); chk_out("bp_sel5", 1, 5, 1);
        drive(1, 12'h0A0, 12'h0A0, 0); step(); chk_out("bp_hold1", 1, 5, 1);
        drive(1, 12'h0A0, 12'h000, 0); step(); chk_out("bp_hold2", 1, 5, 1);
        drive(1, 12'h0A0, 12'h080, 0); step(); chk_out("bp_hold3", 1, 5, 1);
        drive(1, 12'h0A0, 12'h080, 0); step(); chk_out("bp_hold4", 1, 5, 1);
`ifdef NONBLK_SLOT_OVF_EN
        chk("ovf_bp", 32'(ovf_cnt), 32'd6);
`endif
        drive(1, 12'h000, 12'h000, 1); step(); chk_out("bp_rel7", 1, 7, 1);
        step(); chk_out("bp_rel5", 1, 5, 0);
        step(); chk_out("bp_idle", 0, 5, 0);

`ifdef NONBLK_SLOT_OVF_EN
        // Saturation: slots 0 and 1 kept dirty and rewritten every cycle, no acceptance
        drive(0, 12'h000, 12'h000, 0); step();
        chk("ovf_reset", 32'(ovf_cnt), 32'd0);
        for (int k = 1; k <= 300; k++) begin
            drive(1, 12'h003, 12'h003, 0);
            step();
            if (k == 2)   chk("ovf_k2",   32'(ovf_cnt), 32'd1);
            if (k == 128) chk("ovf_k128", 32'(ovf_cnt), 32'd253);
            if (k == 129) chk("ovf_k129", 32'(ovf_cnt), 32'd255);
            if (k == 300) begin
                chk("ovf_k300", 32'(ovf_cnt), 32'd255);
                chk_out("ovf_hold", 1, 0, 1);
            end
        end
`endif

        // Reset mid-transfer drops the presented pair and all pending dirty slots
        drive(1, 12'h00C, 12'h00C, 0); step();
        drive(1, 12'h000, 12'h000, 0); step();
        $display("mid_hold: valid=%0d", out_valid);
        chk("mid_hold.valid", 32'(out_valid), 32'd1);
        drive(0, 12'h000, 12'h000, 0); step(); chk_out("mid_rst", 0, 0, 0);
`ifdef NONBLK_SLOT_OVF_EN
        chk("ovf_mid_rst", 32'(ovf_cnt), 32'd0);
`endif
        drive(1, 12'h000, 12'h000, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("post_rst%0d", k), 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
